// File: rtl/axi_lite_xfer_sequencer_if.sv
// Bundle of command, AXI4-Lite master user-port and local stream signals seen by the sequencer.
// The master modport is the sequencer's view; the slave modport is the surrounding logic's view.
interface axi_lite_xfer_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
);
  logic              cmd_start;
  logic              cmd_store;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0]  cmd_cnt;
  logic              busy;
  logic              done;
  logic              err;
  logic              m_mode;
  logic [31:0]       m_addra;
  logic [31:0]       m_addrb;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_init_txn;
  logic              m_txn_done;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    input  cmd_start, cmd_store, cmd_addr, cmd_cnt,
    output busy, done, err,
    output m_mode, m_addra, m_addrb, m_wdata, m_init_txn,
    input  m_rdata, m_txn_done,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready
  );

  modport slave (
    output cmd_start, cmd_store, cmd_addr, cmd_cnt,
    input  busy, done, err,
    input  m_mode, m_addra, m_addrb, m_wdata, m_init_txn,
    output m_rdata, m_txn_done,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready
  );
endinterface

// File: rtl/axi_lite_xfer_sequencer.sv
// Splits one LOAD/STORE command into single-beat AXI4-Lite master transactions.
// Optional WAIT watchdog with sticky err flag is enabled by defining SEQ_TIMEOUT_EN.
module axi_lite_xfer_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int CNT_W       = 8,
  parameter int ADDR_STRIDE = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                      clk,
  input logic                      reset,
  axi_lite_xfer_sequencer_if.master bus
);

  // IDLE wait cmd | FETCH pull store word | ISSUE pulse init | WAIT await master | PUSH hand load word | DONE pulse done
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, PUSH, DONE} state_t;

  state_t            state;
  logic              store_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  rem_dec;
  logic [ADDR_W-1:0] addr_inc;

  assign rem_dec  = remaining - CNT_W'(1);
  assign addr_inc = cur_addr + ADDR_W'(ADDR_STRIDE);

  assign bus.m_mode   = store_q;
  assign bus.m_addra  = {{(32-ADDR_W){1'b0}}, cur_addr};
  assign bus.m_addrb  = {{(32-ADDR_W){1'b0}}, cur_addr};
  assign bus.wr_ready = (state == FETCH) && bus.wr_valid;

`ifdef SEQ_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0] wdog;
  logic              err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      store_q        <= 1'b0;
      cur_addr       <= '0;
      remaining      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.m_wdata    <= '0;
      bus.m_init_txn <= 1'b0;
      bus.rd_valid   <= 1'b0;
      bus.rd_data    <= '0;
`ifdef SEQ_TIMEOUT_EN
      wdog           <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      bus.done       <= 1'b0;
      bus.m_init_txn <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_start) begin
            store_q   <= bus.cmd_store;
            cur_addr  <= bus.cmd_addr;
            remaining <= bus.cmd_cnt;
            bus.busy  <= 1'b1;
            if (bus.cmd_cnt == '0)  state <= DONE;
            else if (bus.cmd_store) state <= FETCH;
            else                    state <= ISSUE;
          end
        end
        FETCH: begin
          if (bus.wr_valid) begin
            bus.m_wdata <= bus.wr_data;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          bus.m_init_txn <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
          wdog           <= WDOG_W'(TIMEOUT_CYC - 1);
`endif
          state          <= WAIT;
        end
        WAIT: begin
          if (bus.m_txn_done) begin
            if (!store_q) begin
              bus.rd_data  <= bus.m_rdata;
              bus.rd_valid <= 1'b1;
              state        <= PUSH;
            end else begin
              remaining <= rem_dec;
              cur_addr  <= addr_inc;
              state     <= (rem_dec == '0) ? DONE : FETCH;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          // Watchdog expiry abandons the rest of the command but still signals done.
          else if (wdog == '0) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            wdog <= wdog - WDOG_W'(1);
          end
`endif
        end
        PUSH: begin
          if (bus.rd_ready) begin
            bus.rd_valid <= 1'b0;
            remaining    <= rem_dec;
            cur_addr     <= addr_inc;
            state        <= (rem_dec == '0) ? DONE : ISSUE;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_xfer_sequencer.sv
// Directed bench: vector table of LOAD/STORE commands against a latency-2 memory slave,
// plus hand sequences for zero count, back-pressure, mid-command reset and watchdog.
module tb_axi_lite_xfer_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  axi_lite_xfer_sequencer_if #(.DATA_W(32), .ADDR_W(8), .CNT_W(8)) bus ();

  axi_lite_xfer_sequencer #(
    .DATA_W(32), .ADDR_W(8), .CNT_W(8), .ADDR_STRIDE(1), .TIMEOUT_CYC(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic            store;
    logic [7:0]      addr;
    logic [7:0]      cnt;
    logic [3:0][31:0] d;
    logic [7:0]      exp_last;
  } vec_t;

  int tests = 0;
  int failed = 0;
  logic resp_en = 1'b1;
  logic [3:0][31:0] cur_d = '0;
  int wr_base = 0;

  logic [31:0] mem [256];
  int init_cnt = 0, done_cnt = 0, wr_cnt = 0;
  logic [31:0] last_addr = '0;
  logic last_mode = 1'b0;
  logic [31:0] rd_log [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory slave: answers each init pulse two cycles later with a one-cycle txn_done.
  initial begin
    int lat;
    logic [7:0] s_addr;
    logic s_mode;
    logic [31:0] s_wd;
    lat = 0; s_addr = '0; s_mode = 1'b0; s_wd = '0;
    for (int a = 0; a < 256; a++) mem[a] = 32'h5A5A_0000 | a;
    for (int a = 0; a < 4; a++) mem[8'h10 + a] = 32'hA0 + a;
    bus.m_txn_done = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_txn_done = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          bus.m_txn_done = 1'b1;
          if (s_mode) mem[s_addr] = s_wd;
          else        bus.m_rdata = mem[s_addr];
        end
      end
      if (resp_en && bus.m_init_txn) begin
        lat = 2;
        s_addr = bus.m_addra[7:0];
        s_mode = bus.m_mode;
        s_wd = bus.m_wdata;
      end
    end
  end

  // STORE source: presents the next word of cur_d after each consumed word.
  initial begin
    int idx;
    bus.wr_data = '0;
    forever begin
      @(posedge clk);
      #1;
      idx = wr_cnt - wr_base;
      bus.wr_data = (idx >= 0 && idx < 4) ? cur_d[idx] : 32'h0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.m_init_txn) begin
        init_cnt++;
        last_addr = bus.m_addra;
        last_mode = bus.m_mode;
      end
      if (bus.done) done_cnt++;
      if (bus.wr_ready) wr_cnt++;
      if (bus.rd_valid && bus.rd_ready) rd_log.push_back(bus.rd_data);
    end
  end

  task automatic cmd(input logic st, input logic [7:0] a, input logic [7:0] c);
    bus.cmd_store = st;
    bus.cmd_addr  = a;
    bus.cmd_cnt   = c;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int dbase, input string name);
    int n;
    for (n = 0; n < 300 && done_cnt == dbase; n++) tick();
    check({name, "_finished"}, 64'(done_cnt > dbase), 64'd1);
    tick();
    tick();
  endtask

  function automatic vec_t mk(input logic st, input logic [7:0] a, input logic [7:0] c,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [7:0] last);
    vec_t v;
    v.store = st; v.addr = a; v.cnt = c;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.exp_last = last;
    return v;
  endfunction

  initial begin
    vec_t vecs [5];
    int ib, db, wb, rb, n;
    logic [31:0] held;

    vecs[0] = mk(1'b0, 8'h10, 8'd4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 8'h13);
    vecs[1] = mk(1'b1, 8'hFE, 8'd3, 32'h11, 32'h22, 32'h33, 32'h0, 8'h00);
    vecs[2] = mk(1'b0, 8'hFE, 8'd3, 32'h11, 32'h22, 32'h33, 32'h0, 8'h00);
    vecs[3] = mk(1'b1, 8'h7F, 8'd2, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0, 8'h80);
    vecs[4] = mk(1'b0, 8'h7F, 8'd2, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0, 8'h80);

    bus.cmd_start = 1'b0; bus.cmd_store = 1'b0; bus.cmd_addr = '0; bus.cmd_cnt = '0;
    bus.wr_valid = 1'b1; bus.rd_ready = 1'b1;
    #2 reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_init", 64'(bus.m_init_txn), 64'd0);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_addra", 64'(bus.m_addra), 64'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      ib = init_cnt; db = done_cnt; wb = wr_cnt; rb = rd_log.size();
      cur_d = vecs[v].d;
      wr_base = wr_cnt;
      tick();
      cmd(vecs[v].store, vecs[v].addr, vecs[v].cnt);
      wait_done(db, $sformatf("v%0d", v));
      check($sformatf("v%0d_pulses", v), 64'(init_cnt - ib), 64'(vecs[v].cnt));
      check($sformatf("v%0d_done_cnt", v), 64'(done_cnt - db), 64'd1);
      check($sformatf("v%0d_last_addr", v), 64'(last_addr), {56'd0, vecs[v].exp_last});
      check($sformatf("v%0d_mode", v), 64'(last_mode), 64'(vecs[v].store));
      check($sformatf("v%0d_wr_ready", v), 64'(wr_cnt - wb), vecs[v].store ? 64'(vecs[v].cnt) : 64'd0);
      check($sformatf("v%0d_busy", v), 64'(bus.busy), 64'd0);
      for (int i = 0; i < int'(vecs[v].cnt); i++) begin
        if (vecs[v].store)
          check($sformatf("v%0d_mem%0d", v, i), 64'(mem[8'(vecs[v].addr + i)]), 64'(vecs[v].d[i]));
        else if (rb + i < rd_log.size())
          check($sformatf("v%0d_rd%0d", v, i), 64'(rd_log[rb + i]), 64'(vecs[v].d[i]));
        else
          check($sformatf("v%0d_rd%0d_missing", v, i), 64'(rd_log.size()), 64'(rb + i + 1));
      end
    end

    // Zero-length command: done two cycles after the strobe, no transactions.
    ib = init_cnt;
    cmd(1'b0, 8'h33, 8'd0);
    check("cnt0_busy", 64'(bus.busy), 64'd1);
    check("cnt0_done_early", 64'(bus.done), 64'd0);
    tick();
    check("cnt0_done", 64'(bus.done), 64'd1);
    check("cnt0_busy_clr", 64'(bus.busy), 64'd0);
    tick();
    check("cnt0_done_pulse", 64'(bus.done), 64'd0);
    check("cnt0_pulses", 64'(init_cnt - ib), 64'd0);

    // Back-pressure on the first LOAD word; a stray strobe while busy is ignored.
    bus.rd_ready = 1'b0;
    ib = init_cnt; db = done_cnt; rb = rd_log.size();
    cmd(1'b0, 8'h10, 8'd2);
    for (n = 0; n < 50 && !bus.rd_valid; n++) tick();
    check("bp_rd_valid_rise", 64'(bus.rd_valid), 64'd1);
    held = bus.rd_data;
    check("bp_word0", 64'(held), 64'hA0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.cmd_store = 1'b1; bus.cmd_addr = 8'h50; bus.cmd_cnt = 8'd9; bus.cmd_start = 1'b1;
      end else begin
        bus.cmd_start = 1'b0;
      end
      tick();
      check($sformatf("bp_hold_valid%0d", k), 64'(bus.rd_valid), 64'd1);
      check($sformatf("bp_hold_data%0d", k), 64'(bus.rd_data), 64'hA0);
    end
    bus.cmd_start = 1'b0;
    check("bp_single_init", 64'(init_cnt - ib), 64'd1);
    bus.rd_ready = 1'b1;
    wait_done(db, "bp");
    check("bp_pulses", 64'(init_cnt - ib), 64'd2);
    check("bp_rd_count", 64'(rd_log.size() - rb), 64'd2);
    if (rd_log.size() - rb == 2) begin
      check("bp_rd0", 64'(rd_log[rb]), 64'hA0);
      check("bp_rd1", 64'(rd_log[rb + 1]), 64'hA1);
    end
    repeat (10) tick();
    check("bp_no_stray_cmd", 64'(init_cnt - ib), 64'd2);
    check("bp_done_once", 64'(done_cnt - db), 64'd1);

    // Reset while a STORE sits in WAIT.
    resp_en = 1'b0;
    ib = init_cnt;
    cur_d[0] = 32'hCAFE0001; cur_d[1] = 32'hCAFE0002; cur_d[2] = 32'hCAFE0003; cur_d[3] = 32'hCAFE0004;
    wr_base = wr_cnt;
    tick();
    cmd(1'b1, 8'h40, 8'd4);
    for (n = 0; n < 50 && init_cnt == ib; n++) tick();
    check("rstmid_in_wait", 64'(init_cnt - ib), 64'd1);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    check("rstmid_mode", 64'(bus.m_mode), 64'd0);
    check("rstmid_addra", 64'(bus.m_addra), 64'd0);
    check("rstmid_wdata", 64'(bus.m_wdata), 64'd0);
    check("rstmid_init", 64'(bus.m_init_txn), 64'd0);
    tick();
    reset = 1'b0;
    resp_en = 1'b1;
    repeat (3) tick();
    check("rstmid_no_init", 64'(init_cnt - ib), 64'd1);
    check("rstmid_mem_untouched", 64'(mem[8'h40]), 64'h5A5A0040);
    ib = init_cnt; db = done_cnt; rb = rd_log.size();
    cmd(1'b0, 8'h11, 8'd1);
    wait_done(db, "post_rst");
    check("post_rst_pulses", 64'(init_cnt - ib), 64'd1);
    if (rd_log.size() > rb) check("post_rst_rd", 64'(rd_log[rb]), 64'hA1);
    else check("post_rst_rd_missing", 64'(rd_log.size()), 64'(rb + 1));

`ifdef SEQ_TIMEOUT_EN
    // Master never answers: 16 WAIT cycles, then DONE, done visible the cycle after.
    resp_en = 1'b0;
    ib = init_cnt;
    cmd(1'b0, 8'h20, 8'd2);
    for (n = 0; n < 50 && !bus.m_init_txn; n++) tick();
    check("to_init_seen", 64'(bus.m_init_txn), 64'd1);
    for (n = 0; n < 100 && !bus.done; n++) tick();
    check("to_done_latency", 64'(n), 64'd17);
    check("to_err", 64'(bus.err), 64'd1);
    check("to_pulses", 64'(init_cnt - ib), 64'd1);
    resp_en = 1'b1;
    tick();
    ib = init_cnt; db = done_cnt; rb = rd_log.size();
    cmd(1'b0, 8'h12, 8'd1);
    check("to_err_sticky_busy", 64'(bus.err), 64'd1);
    wait_done(db, "to_next");
    check("to_err_sticky", 64'(bus.err), 64'd1);
    if (rd_log.size() > rb) check("to_next_rd", 64'(rd_log[rb]), 64'hA2);
    else check("to_next_rd_missing", 64'(rd_log.size()), 64'(rb + 1));
`else
    check("err_tied_low", 64'(bus.err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
